// File: rtl/inst_fetch_queue_if.sv
// Handshake and data bundle between the IF stage, the fetch queue and ID.
// The master side is IF/ID together, because it drives the queue's inputs.
// The slave side is the queue.
interface inst_fetch_queue_if #(
  parameter int ADDR_BIT = 10,
  parameter int PTR_BIT  = 2
);
  logic                en;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_BIT-1:0] in_pc_4;
  logic [31:0]         in_inst;
  logic                out_ready;
  logic                out_valid;
  logic [ADDR_BIT-1:0] out_pc_4;
  logic [31:0]         out_inst;
  logic [PTR_BIT:0]    count;

  modport master (
    output en, flush, in_valid, in_pc_4, in_inst, out_ready,
    input  in_ready, out_valid, out_pc_4, out_inst, count
  );

  modport slave (
    input  en, flush, in_valid, in_pc_4, in_inst, out_ready,
    output in_ready, out_valid, out_pc_4, out_inst, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular FIFO of {pc_4, inst} pairs that sits between IF and ID.
// - IF keeps fetching while ID stalls.
// - An EX redirect (flush) discards every queued entry.
// - When the queue is empty, ID sees a NOP bubble (zeros).
module inst_fetch_queue #(
  parameter int ADDR_BIT = 10,
  parameter int DEPTH    = 4,
  parameter int PTR_BIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_queue_if.slave q
);
  localparam logic [PTR_BIT:0] FULL = (PTR_BIT+1)'(DEPTH);

  logic [ADDR_BIT+31:0] mem [DEPTH];
  logic [PTR_BIT-1:0]   wr_ptr;
  logic [PTR_BIT-1:0]   rd_ptr;
  logic [PTR_BIT:0]     count_q;
  logic                 push;
  logic                 pop;
  logic [ADDR_BIT+31:0] head;

  // Handshake qualification.
  // in_ready depends on the count alone, so there is no combinational path from ID back to IF.
  always_comb begin
    q.in_ready  = (count_q != FULL);
    q.out_valid = (count_q != '0);
    push        = q.en & q.in_valid & q.in_ready & ~q.flush;
    pop         = q.en & q.out_ready & q.out_valid & ~q.flush;
  end

  // Pointer and occupancy registers.
  // Pointers wrap naturally at DEPTH.
  // flush restarts the ring at slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.en) begin
      if (q.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry storage.
  // It is not reset, because the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {q.in_pc_4, q.in_inst};
  end

  // Head read-out.
  // The outputs come only from storage, gated to zero when the queue is empty.
  // There is never a bypass from in_*.
  always_comb begin
    head       = mem[rd_ptr];
    q.out_inst = q.out_valid ? head[31:0] : 32'd0;
    q.out_pc_4 = q.out_valid ? head[ADDR_BIT+31:32] : '0;
    q.count    = count_q;
  end
endmodule
